// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache refill controller.
//   CACHE_*_WIDTH  : default widths used by lru_table and cache_refill_ctrl
//   refill_state_t : refill FSM state encoding
//   fill_t         : one fill beat handed back to the cache
package cache_pkg;

  localparam int unsigned CACHE_DATA_WIDTH = 32;
  localparam int unsigned CACHE_ADDR_WIDTH = 32;
  localparam int unsigned CACHE_SET_WIDTH  = 2;
  localparam int unsigned CACHE_TAG_WIDTH  = CACHE_ADDR_WIDTH - CACHE_SET_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } refill_state_t;

  typedef struct packed {
    logic [CACHE_SET_WIDTH-1:0]  set;
    logic                        way;
    logic [CACHE_TAG_WIDTH-1:0]  tag;
    logic [CACHE_DATA_WIDTH-1:0] data;
  } fill_t;

endpackage

// File: rtl/lru_table.sv
// Per-set LRU bit store for a 2-way cache. Each bit names the way to evict next.
//   i_clk, i_rst     : clock, synchronous active-high clear (all bits to 0)
//   i_rd_set         : set to look up
//   o_rd_way         : victim way for i_rd_set (combinational read)
//   i_upd_en         : update strobe
//   i_upd_set        : set being updated
//   i_upd_used_way   : way just used; the other way becomes the victim
module lru_table
  import cache_pkg::*;
#(
  parameter int unsigned SET_WIDTH = CACHE_SET_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SET_WIDTH-1:0] i_rd_set,
  output logic                 o_rd_way,
  input  logic                 i_upd_en,
  input  logic [SET_WIDTH-1:0] i_upd_set,
  input  logic                 i_upd_used_way
);

  localparam int unsigned NUM_SETS = 2 ** SET_WIDTH;

  logic [NUM_SETS-1:0] r_lru;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lru <= '0;
    end else if (i_upd_en) begin
      r_lru[i_upd_set] <= ~i_upd_used_way;
    end
  end

  assign o_rd_way = r_lru[i_rd_set];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling stage behind a 2-way set-associative data cache. A miss is
// fetched from memory with a req/ack handshake, then written back to the
// cache as a single fill beat into the LRU victim way. The CPU is stalled
// from the miss cycle until the fill beat.
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_miss_valid, i_miss_addr  : miss report from the cache (addr bits [1:0] ignored)
//   i_hit_valid, i_hit_set, i_hit_way : hit report, refreshes LRU
//   o_mem_req, o_mem_addr      : memory read request, word-aligned address
//   i_mem_ack, i_mem_rdata     : memory read data strobe and data
//   o_fill_valid, o_fill_*     : one-cycle fill strobe with set/way/tag/data
//   o_stall                    : CPU pipeline freeze (combinational)
// Optional (macro CACHE_REFILL_STATS_EN):
//   o_miss_count               : saturating count of accepted misses
//   o_stall_cycles             : saturating count of stalled cycles
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CACHE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int unsigned SET_WIDTH  = CACHE_SET_WIDTH,
  parameter int unsigned TAG_WIDTH  = ADDR_WIDTH - SET_WIDTH - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_miss_valid,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  i_hit_valid,
  input  logic [SET_WIDTH-1:0]  i_hit_set,
  input  logic                  i_hit_way,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_fill_valid,
  output logic [SET_WIDTH-1:0]  o_fill_set,
  output logic                  o_fill_way,
  output logic [TAG_WIDTH-1:0]  o_fill_tag,
  output logic [DATA_WIDTH-1:0] o_fill_data,
`ifdef CACHE_REFILL_STATS_EN
  output logic [31:0]           o_miss_count,
  output logic [31:0]           o_stall_cycles,
`endif
  output logic                  o_stall
);

  refill_state_t r_state, w_state_next;

  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_fill_valid;
  fill_t                 r_fill;

  logic                  w_stall;
  logic                  w_start;
  logic                  w_ack;
  logic [SET_WIDTH-1:0]  w_req_set;
  logic [TAG_WIDTH-1:0]  w_req_tag;
  logic                  w_victim_way;
  logic                  w_lru_upd_en;
  logic [SET_WIDTH-1:0]  w_lru_upd_set;
  logic                  w_lru_upd_way;
  logic                  w_unused_addr_lsb;

  // Byte offset never reaches memory or the cache tag.
  assign w_unused_addr_lsb = ^i_miss_addr[1:0];

  // The latched request address doubles as the miss address store.
  assign w_req_set = r_mem_addr[SET_WIDTH+1:2];
  assign w_req_tag = r_mem_addr[ADDR_WIDTH-1:SET_WIDTH+2];

  assign w_start = (r_state == IDLE) && i_miss_valid;
  assign w_ack   = (r_state == REQ) && i_mem_ack;

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_stall = i_miss_valid;
        if (i_miss_valid) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (i_mem_ack) begin
          w_state_next = FILL;
        end
      end
      FILL: begin
        w_stall      = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // LRU update: hits in IDLE (a simultaneous miss wins), and the fill beat itself.
  always_comb begin
    w_lru_upd_en  = 1'b0;
    w_lru_upd_set = i_hit_set;
    w_lru_upd_way = i_hit_way;
    unique case (r_state)
      IDLE: begin
        w_lru_upd_en = i_hit_valid && !i_miss_valid;
      end
      FILL: begin
        w_lru_upd_en  = 1'b1;
        w_lru_upd_set = r_fill.set;
        w_lru_upd_way = r_fill.way;
      end
      default: begin
        w_lru_upd_en = 1'b0;
      end
    endcase
  end

  lru_table #(
    .SET_WIDTH (SET_WIDTH)
  ) u_lru_table (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_rd_set       (w_req_set),
    .o_rd_way       (w_victim_way),
    .i_upd_en       (w_lru_upd_en),
    .i_upd_set      (w_lru_upd_set),
    .i_upd_used_way (w_lru_upd_way)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_fill_valid <= 1'b0;
      r_fill       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fill_valid <= w_ack;
      if (w_start) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= {i_miss_addr[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_ack) begin
        r_mem_req <= 1'b0;
      end
      // Fill fields change only with the strobe so they hold between fills.
      // LRU is stable throughout REQ, so the victim read at ack is the one filled.
      if (w_ack) begin
        r_fill.set  <= w_req_set;
        r_fill.way  <= w_victim_way;
        r_fill.tag  <= w_req_tag;
        r_fill.data <= i_mem_rdata;
      end
    end
  end

`ifdef CACHE_REFILL_STATS_EN
  logic [31:0] r_miss_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_miss_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_start && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign o_miss_count   = r_miss_count;
  assign o_stall_cycles = r_stall_cycles;
`endif

  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;
  assign o_fill_valid = r_fill_valid;
  assign o_fill_set   = r_fill.set;
  assign o_fill_way   = r_fill.way;
  assign o_fill_tag   = r_fill.tag;
  assign o_fill_data  = r_fill.data;
  assign o_stall      = w_stall;

endmodule
